// File: rtl/scfifo_pkg.sv
// scfifo_pkg: read-mode constants, address/count width helpers and the
// show-ahead prefetch state type shared by scfifo_param and sdp_ram.
package scfifo_pkg;

   localparam int unsigned FIFO_MODE_NORMAL    = 0;
   localparam int unsigned FIFO_MODE_SHOWAHEAD = 1;

   typedef enum logic {
      EMPTY      = 1'b0,
      HEAD_VALID = 1'b1
   } pf_state_e;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so the occupancy can represent DEPTH exactly.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return addr_width(depth) + 1;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port storage, one write port and one registered read
// port; the array itself is never reset so it maps onto block RAM.
module sdp_ram
   import scfifo_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned AW          = addr_width(DEPTH),
   parameter bit          WRITE_FIRST = 1'b0
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // WRITE_FIRST forwards same-address write data; otherwise old data is read.
   always_ff @(posedge clock) begin
      if (sclr) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= (WRITE_FIRST && we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/scfifo_param.sv
// scfifo_param: parametrised single-clock FIFO with normal or show-ahead read,
// exact occupancy, programmable almost flags and sticky error flags.
module scfifo_param
   import scfifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned SHOWAHEAD = FIFO_MODE_NORMAL,
   parameter int unsigned AF_LEVEL  = DEPTH - 4,
   parameter int unsigned AE_LEVEL  = 4
) (
   input  logic                        clock,
   input  logic                        sclr,
   input  logic [WIDTH-1:0]            data,
   input  logic                        wrreq,
   input  logic                        rdreq,
   output logic [WIDTH-1:0]            q,
   output logic [cnt_width(DEPTH)-1:0] usedw,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int unsigned AW = addr_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);
   localparam bit          SA = (SHOWAHEAD == FIFO_MODE_SHOWAHEAD);

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $fatal(1, "scfifo_param: DEPTH must be a power of 2 and >= 4");
   end
   if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
      $fatal(1, "scfifo_param: need AE_LEVEL < AF_LEVEL <= DEPTH");
   end
   if (SHOWAHEAD > FIFO_MODE_SHOWAHEAD) begin : g_bad_mode
      $fatal(1, "scfifo_param: SHOWAHEAD must be 0 or 1");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty_q, empty_d, full_q, full_d;
   logic          af_q, af_d, ae_q, ae_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   pf_state_e     pf_q, pf_d;
   logic          wr_acc, rd_acc, ram_re;
   logic [AW-1:0] ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   always_comb begin
      rd_acc   = rdreq && !empty_q;
      wr_acc   = wrreq && (!full_q || rd_acc);
      wr_ptr_d = wr_ptr_q + AW'(wr_acc);
      rd_ptr_d = rd_ptr_q + AW'(rd_acc);
      cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
      empty_d  = (cnt_d == '0);
      full_d   = (cnt_d == CW'(DEPTH));
      af_d     = (cnt_d >= CW'(AF_LEVEL));
      ae_d     = (cnt_d <= CW'(AE_LEVEL));
      ovf_d    = ovf_q || (wrreq && !wr_acc);
      unf_d    = unf_q || (rdreq && empty_q);
   end

   // Show-ahead keeps the RAM read register loaded with the head word by
   // reading at the post-pop pointer; it only reloads on fill or pop so that
   // q holds the last popped word once the FIFO drains.
   always_comb begin
      pf_d      = pf_q;
      ram_re    = rd_acc;
      ram_raddr = rd_ptr_q;
      if (SA) begin
         ram_raddr = rd_ptr_d;
         ram_re    = 1'b0;
         case (pf_q)
            EMPTY: begin
               if (wr_acc) begin
                  ram_re = 1'b1;
                  pf_d   = HEAD_VALID;
               end
            end
            HEAD_VALID: begin
               if (cnt_d == '0) begin
                  pf_d = EMPTY;
               end else begin
                  ram_re = rd_acc;
               end
            end
            default: pf_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         pf_q     <= EMPTY;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         pf_q     <= pf_d;
      end
   end

   sdp_ram #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AW          (AW),
      .WRITE_FIRST (SA)
   ) u_ram (
      .clock (clock),
      .sclr  (sclr),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (data),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign q            = ram_rdata;
   assign usedw        = cnt_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_scfifo_param.sv
// tb_scfifo_param: drives a normal-mode DEPTH=4 FIFO and a show-ahead DEPTH=8
// FIFO with the same stimulus and checks both against queue-based models.
module tb_scfifo_param;

   localparam int unsigned W   = 16;
   localparam int unsigned D0  = 4;
   localparam int unsigned AF0 = 3;
   localparam int unsigned AE0 = 1;
   localparam int unsigned D1  = 8;
   localparam int unsigned AF1 = 6;
   localparam int unsigned AE1 = 2;

   logic         clk   = 1'b0;
   logic         sclr  = 1'b1;
   logic         wrreq = 1'b0;
   logic         rdreq = 1'b0;
   logic [W-1:0] data  = '0;

   logic [W-1:0] q0, q1;
   logic [2:0]   usedw0;
   logic [3:0]   usedw1;
   logic         empty0, full0, af0, ae0, ovf0, unf0;
   logic         empty1, full1, af1, ae1, ovf1, unf1;

   always #5 clk = ~clk;

   scfifo_param #(
      .WIDTH (W), .DEPTH (D0), .SHOWAHEAD (0), .AF_LEVEL (AF0), .AE_LEVEL (AE0)
   ) u_nrm (
      .clock (clk), .sclr (sclr), .data (data), .wrreq (wrreq), .rdreq (rdreq),
      .q (q0), .usedw (usedw0), .empty (empty0), .full (full0),
      .almost_full (af0), .almost_empty (ae0), .overflow (ovf0), .underflow (unf0)
   );

   scfifo_param #(
      .WIDTH (W), .DEPTH (D1), .SHOWAHEAD (1), .AF_LEVEL (AF1), .AE_LEVEL (AE1)
   ) u_sha (
      .clock (clk), .sclr (sclr), .data (data), .wrreq (wrreq), .rdreq (rdreq),
      .q (q1), .usedw (usedw1), .empty (empty1), .full (full1),
      .almost_full (af1), .almost_empty (ae1), .overflow (ovf1), .underflow (unf1)
   );

   typedef struct {
      int unsigned  usedw;
      bit           empty, full, af, ae, ovf, unf;
      logic [W-1:0] q;
   } exp_t;

   logic [W-1:0] mdl   [2][$];
   exp_t         exp_q [2][$];
   bit           m_ovf [2];
   bit           m_unf [2];
   logic [W-1:0] m_q   [2];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_fail = 0;

   task automatic chk(input string name, input int unsigned inst,
                      input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s[%0d] t=%0t: got %0h, expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // Reference model: each FIFO is a queue of words; expected outputs after
   // every edge are pushed to the scoreboard.
   initial begin
      int unsigned dep, afl, ael, sz;
      bit          rd_ok, wr_ok;
      exp_t        e;
      forever begin
         @(posedge clk);
         for (int i = 0; i < 2; i++) begin
            dep = (i == 0) ? D0 : D1;
            afl = (i == 0) ? AF0 : AF1;
            ael = (i == 0) ? AE0 : AE1;
            if (sclr) begin
               mdl[i].delete();
               m_ovf[i] = 1'b0;
               m_unf[i] = 1'b0;
               m_q[i]   = '0;
            end else begin
               rd_ok = rdreq && (mdl[i].size() != 0);
               wr_ok = wrreq && ((mdl[i].size() < int'(dep)) || rd_ok);
               if (rdreq && !rd_ok) m_unf[i] = 1'b1;
               if (wrreq && !wr_ok) m_ovf[i] = 1'b1;
               if (rd_ok) m_q[i] = mdl[i].pop_front();
               if (wr_ok) mdl[i].push_back(data);
            end
            sz      = mdl[i].size();
            e.usedw = sz;
            e.empty = (sz == 0);
            e.full  = (sz == dep);
            e.af    = (sz >= afl);
            e.ae    = (sz <= ael);
            e.ovf   = m_ovf[i];
            e.unf   = m_unf[i];
            e.q     = ((i == 1) && (sz != 0)) ? mdl[i][0] : m_q[i];
            exp_q[i].push_back(e);
         end
      end
   end

   // Monitor: compares DUT outputs mid-cycle against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q[0].size() != 0) begin
            e = exp_q[0].pop_front();
            chk("usedw", 0, 32'(usedw0), e.usedw);
            chk("empty", 0, 32'(empty0), 32'(e.empty));
            chk("full",  0, 32'(full0),  32'(e.full));
            chk("afull", 0, 32'(af0),    32'(e.af));
            chk("aempty",0, 32'(ae0),    32'(e.ae));
            chk("ovf",   0, 32'(ovf0),   32'(e.ovf));
            chk("unf",   0, 32'(unf0),   32'(e.unf));
            chk("q",     0, 32'(q0),     32'(e.q));
         end
         if (exp_q[1].size() != 0) begin
            e = exp_q[1].pop_front();
            chk("usedw", 1, 32'(usedw1), e.usedw);
            chk("empty", 1, 32'(empty1), 32'(e.empty));
            chk("full",  1, 32'(full1),  32'(e.full));
            chk("afull", 1, 32'(af1),    32'(e.af));
            chk("aempty",1, 32'(ae1),    32'(e.ae));
            chk("ovf",   1, 32'(ovf1),   32'(e.ovf));
            chk("unf",   1, 32'(unf1),   32'(e.unf));
            chk("q",     1, 32'(q1),     32'(e.q));
         end
      end
   end

   task automatic cyc(input bit s, input bit w, input bit r, input logic [W-1:0] d);
      @(negedge clk);
      sclr  = s;
      wrreq = w;
      rdreq = r;
      data  = d;
   endtask

   initial begin
      int unsigned pw, pr;

      cyc(1, 0, 0, '0);
      cyc(1, 0, 0, '0);

      // Write 1,2,3, idle, then read them back one at a time; final read underflows.
      cyc(0, 1, 0, 16'd1);
      cyc(0, 1, 0, 16'd2);
      cyc(0, 1, 0, 16'd3);
      repeat (3) cyc(0, 0, 0, '0);
      repeat (4) begin
         cyc(0, 0, 1, '0);
         cyc(0, 0, 0, '0);
      end
      cyc(0, 1, 1, 16'h0BEE);
      cyc(0, 0, 0, '0);

      // Single word into empty, then pop it.
      cyc(1, 0, 0, '0);
      cyc(0, 1, 0, 16'h00AA);
      cyc(0, 0, 0, '0);
      cyc(0, 0, 1, '0);
      cyc(0, 0, 0, '0);

      // Fill 10..13, simultaneous write 20 + read on full, drain.
      cyc(1, 0, 0, '0);
      for (int k = 10; k < 14; k++) cyc(0, 1, 0, W'(k));
      cyc(0, 1, 1, 16'd20);
      repeat (5) cyc(0, 0, 1, '0);

      // Overfill with 10..14, drain.
      cyc(1, 0, 0, '0);
      for (int k = 10; k < 15; k++) cyc(0, 1, 0, W'(k));
      repeat (5) cyc(0, 0, 1, '0);

      // Threshold sweep: fill past DEPTH then empty completely.
      cyc(1, 0, 0, '0);
      for (int k = 0; k < 9; k++) cyc(0, 1, 0, W'(16'h0300 + k));
      repeat (9) cyc(0, 0, 1, '0);

      // Full-rate streaming across pointer wrap, then sclr mid-stream.
      cyc(1, 0, 0, '0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, W'(16'h0700 + k));
      for (int k = 0; k < 1000; k++) cyc(0, 1, 1, W'(16'h1000 + k));
      cyc(1, 1, 1, 16'hFFFF);
      cyc(0, 1, 0, 16'h0055);
      cyc(0, 0, 0, '0);
      cyc(0, 0, 1, '0);
      cyc(0, 0, 0, '0);

      // Randomised traffic with varying write/read pressure and rare resets.
      for (int blk = 0; blk < 15; blk++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int k = 0; k < 100; k++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < pw,
                $urandom_range(0, 99) < pr,
                W'($urandom));
         end
      end

      repeat (3) cyc(0, 0, 0, '0);
      @(negedge clk);
      #1;
      chk("sb_drain", 0, exp_q[0].size(), 0);
      chk("sb_drain", 1, exp_q[1].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/scfifo_param.md
Name: scfifo_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed 64x256 scfifo buffering used between the MDP3.0 packet parser and downstream message decoders.
- Adds generic width and depth.
- Adds selectable normal or show-ahead read mode.
- Adds programmable almost-full/almost-empty thresholds, an exact-count usedw, and sticky overflow/underflow error flags.
- Pure RTL; the storage array maps to inferred block RAM.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 256, number of entries; power of 2, >= 4
SHOWAHEAD, 0, 0 = normal mode (q valid 1 cycle after rdreq); 1 = show-ahead mode (q presents head word while !empty)
AF_LEVEL, DEPTH-4, almost_full asserts when usedw >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when usedw <= AE_LEVEL

Ports:
clock  in  1  system clock; all logic on rising edge
sclr  in  1  synchronous active-high reset
data  in  WIDTH  write data
wrreq  in  1  write request
rdreq  in  1  read request / head acknowledge in show-ahead
q  out  WIDTH  read data
usedw  out  $clog2(DEPTH)+1  exact occupancy, 0..DEPTH
empty  out  1  usedw == 0
full  out  1  usedw == DEPTH
almost_full  out  1  usedw >= AF_LEVEL
almost_empty  out  1  usedw <= AE_LEVEL
overflow  out  1  sticky: write rejected while full
underflow  out  1  sticky: read requested while empty

Behaviour:
- Reset: one clock, synchronous, active-high; sclr has priority over everything.
  - Outputs after reset: usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0.
  - Pointers are cleared; RAM contents are not cleared.
  - sclr mid-operation discards all stored words in that cycle; wrreq/rdreq in the sclr cycle are ignored.
- Accepted write: wrreq && (!full || rdreq_accepted).
  - A write to a full FIFO is permitted when a read is accepted in the same cycle.
- Accepted read: rdreq && !empty.
- Rejected operations:
  - Rejected write: word is dropped, overflow set.
  - Rejected read: underflow set; q unchanged.
- Simultaneous accepted read and write: usedw unchanged; both pointers advance.
- Read on empty with a same-cycle write: the write is accepted, the read is rejected and underflow is set.
- Occupancy and flags:
  - usedw, empty, full, almost_* are registered.
  - All update in the cycle after the request edge.
  - Count is exact: it never wraps, and full is equivalent to usedw == DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The DEPTH-1 -> 0 transition is seamless.
- Normal mode (SHOWAHEAD=0):
  - q is registered RAM output, updated in the cycle after an accepted read.
  - q holds its value otherwise.
- Show-ahead mode (SHOWAHEAD=1):
  - q equals the head word whenever empty=0.
  - An accepted rdreq pops the head; the next word appears on q in the following cycle.
  - Write into empty FIFO: empty deasserts and q is valid in the same cycle (1-cycle latency from wrreq).
  - Implemented with a one-entry prefetch register in front of the synchronous RAM.
  - Prefetch state machine states: EMPTY, HEAD_VALID. Reading and writing the same address in one cycle must bypass the RAM (write data forwarded).
  - Back-to-back pops at full rate are sustained with no bubbles.
  - When empty, q holds the last popped word.
- Throughput: one write and one read per cycle, sustained, in both modes.
- Elaboration checks:
  - DEPTH must be a power of 2.
  - AE_LEVEL must be < AF_LEVEL <= DEPTH.
  - A violation is a fatal elaboration error.

Decomposition:
- Package scfifo_pkg: constant helper function for the address/count widths; FIFO_MODE_NORMAL / FIFO_MODE_SHOWAHEAD constants; prefetch state enum.
- Sub-module sdp_ram (simple dual-port, one write port, one registered read port, WIDTH x DEPTH, no reset on array).
- Top-level holds pointers, counter, flags, prefetch logic.

Test Plan:
- WIDTH=64, DEPTH=256, normal mode:
  - Write 1,2,3 on consecutive cycles, then idle 3 cycles -> usedw=3, empty=0.
  - Then pulse rdreq 1 cycle -> q=1 next cycle, usedw=2.
  - Next rdreq -> q=2.
- Show-ahead, DEPTH=8:
  - Single write of 0xAA into empty -> next cycle empty=0, q=0xAA with no rdreq.
  - Then rdreq -> empty=1, usedw=0.
- DEPTH=4:
  - Write 5 words 10..14 -> full=1 after 4th, usedw=4, overflow=1, word 14 dropped.
  - Drain -> q sequence 10,11,12,13.
- DEPTH=4 full:
  - Simultaneous wrreq(20)+rdreq -> usedw stays 4, full stays 1, overflow=0.
  - Subsequent drain yields 11,12,13,20 (given prior contents 10..13).
- Wrap and reset:
  - Stream 1000 words with rdreq and wrreq both high every cycle (DEPTH=8, show-ahead) -> output order identical to input, no bubbles, usedw constant.
  - Then sclr mid-stream -> next cycle usedw=0, empty=1, flags cleared, subsequent write 0x55 read back correctly.
- Underflow and thresholds:
  - rdreq on empty -> underflow=1, stays 1 until sclr.
  - AF_LEVEL=6/AE_LEVEL=2, DEPTH=8 -> almost_full rises on 6th write, almost_empty falls on 3rd.
